// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell codes, controller states, win-line table.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package ttt_pkg;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'b00,
      CELL_P1    = 2'b01,
      CELL_P2    = 2'b10
   } cell_t;

   typedef enum logic [2:0] {
      ST_P1_WAIT   = 3'd0,
      ST_P2_WAIT   = 3'd1,
      ST_CPU_THINK = 3'd2,
      ST_EVAL      = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_t;

   localparam int NUM_CELLS = 9;
   localparam int NUM_LINES = 8;

   // Cell index triples, entry 0 in the low bits.
   // Cells are row-major: a=0 b=1 c=2 / d=3 e=4 f=5 / g=6 h=7 i=8.
   localparam logic [NUM_LINES-1:0][2:0][3:0] WIN_LINES = {
      {4'd6, 4'd4, 4'd2},   // 7: diagonal c-e-g
      {4'd8, 4'd4, 4'd0},   // 6: diagonal a-e-i
      {4'd8, 4'd5, 4'd2},   // 5: column c-f-i
      {4'd7, 4'd4, 4'd1},   // 4: column b-e-h
      {4'd6, 4'd3, 4'd0},   // 3: column a-d-g
      {4'd8, 4'd7, 4'd6},   // 2: row g-h-i
      {4'd5, 4'd4, 4'd3},   // 1: row d-e-f
      {4'd2, 4'd1, 4'd0}    // 0: row a-b-c
   };

   // Two-bit code of one cell in a packed board.
   function automatic logic [1:0] cell_at(input logic [2*NUM_CELLS-1:0] board, input int idx);
      return board[2*idx +: 2];
   endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Flags whether the given player owns all three cells of any win line.
// Latency: purely combinational.
// Backpressure: none.
module ttt_win_detect
   import ttt_pkg::*;
(
   input  logic [2*NUM_CELLS-1:0] board_i,
   input  cell_t                  player_i,
   output logic                   line_o
);

   // Scan all eight lines; an empty player code never matches.
   always_comb begin
      line_o = 1'b0;
      for (int l = 0; l < NUM_LINES; l++) begin
         if (player_i != CELL_EMPTY &&
             cell_at(board_i, int'(WIN_LINES[l][0])) == player_i &&
             cell_at(board_i, int'(WIN_LINES[l][1])) == player_i &&
             cell_at(board_i, int'(WIN_LINES[l][2])) == player_i) begin
            line_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe turn controller: button edge capture, board, win/draw, CPU opponent.
// Latency: board updates on the press-detect edge; turn/win/full flags one clock later.
// Backpressure: none; presses that are not accepted are simply dropped.
module ttt_turn_ctrl
   import ttt_pkg::*;
#(
   parameter int CPU_DELAY = 4
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_CELLS-1:0]   btn,
   input  logic                   game_mode,
   output logic [2*NUM_CELLS-1:0] cell_led,
   output logic                   p1_turn,
   output logic                   p2_turn,
   output logic                   p1_win,
   output logic                   p2_win,
   output logic                   grid_full
);

   localparam int CW = (CPU_DELAY < 2) ? 1 : $clog2(CPU_DELAY);

   state_t                 state_q, state_d;
   logic [2*NUM_CELLS-1:0] board_q, board_d;
   cell_t                  last_mover_q, last_mover_d;
   logic                   mode_q, mode_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   p1_win_q, p1_win_d;
   logic                   p2_win_q, p2_win_d;
   logic                   full_q, full_d;
   logic [NUM_CELLS-1:0]   btn_q;
   logic                   arm_q;

   logic [NUM_CELLS-1:0]   press;
   logic                   press_one_hot;
   logic                   press_on_empty;
   logic [NUM_CELLS-1:0]   empty_mask;
   logic [NUM_CELLS-1:0]   cpu_sel;
   logic                   cpu_found;
   logic                   cpu_done;
   logic                   board_full;
   logic                   line_done;
   logic [NUM_CELLS-1:0]   wr_mask;
   cell_t                  wr_code;

   // arm_q masks the first clock after reset so a button held through
   // release is absorbed into btn_q instead of being seen as a press.
   assign press          = btn & ~btn_q & {NUM_CELLS{arm_q}};
   assign press_one_hot  = (press != '0) && ((press & (press - 9'd1)) == '0);
   assign press_on_empty = |(press & empty_mask);
   assign board_full     = (empty_mask == '0);
   assign cpu_done       = (int'(cnt_q) >= CPU_DELAY - 1);

   // Per-cell empty flags and the lowest-index empty cell for the CPU move.
   always_comb begin
      empty_mask = '0;
      cpu_sel    = '0;
      cpu_found  = 1'b0;
      for (int k = 0; k < NUM_CELLS; k++) begin
         empty_mask[k] = (board_q[2*k +: 2] == CELL_EMPTY);
         if (!cpu_found && empty_mask[k]) begin
            cpu_sel[k] = 1'b1;
            cpu_found  = 1'b1;
         end
      end
   end

   // Only the player who just moved can have completed a line.
   ttt_win_detect u_win_detect (
      .board_i  (board_q),
      .player_i (last_mover_q),
      .line_o   (line_done)
   );

   // Next-state, board write and flag updates.
   always_comb begin
      state_d      = state_q;
      board_d      = board_q;
      last_mover_d = last_mover_q;
      mode_d       = mode_q;
      cnt_d        = cnt_q;
      p1_win_d     = p1_win_q;
      p2_win_d     = p2_win_q;
      full_d       = full_q;
      wr_mask      = '0;
      wr_code      = CELL_EMPTY;

      case (state_q)
         ST_P1_WAIT: begin
            // Mode only follows the switch before the first move of a game.
            if (board_q == '0) mode_d = game_mode;
            if (press_one_hot && press_on_empty) begin
               wr_mask      = press;
               wr_code      = CELL_P1;
               last_mover_d = CELL_P1;
               state_d      = ST_EVAL;
            end
         end
         ST_P2_WAIT: begin
            if (press_one_hot && press_on_empty) begin
               wr_mask      = press;
               wr_code      = CELL_P2;
               last_mover_d = CELL_P2;
               state_d      = ST_EVAL;
            end
         end
         ST_CPU_THINK: begin
            if (cpu_done) begin
               wr_mask      = cpu_sel;
               wr_code      = CELL_P2;
               last_mover_d = CELL_P2;
               cnt_d        = '0;
               state_d      = ST_EVAL;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_EVAL: begin
            cnt_d = '0;
            if (line_done) begin
               if (last_mover_q == CELL_P1) p1_win_d = 1'b1;
               else                         p2_win_d = 1'b1;
               if (board_full) full_d = 1'b1;
               state_d = ST_GAME_OVER;
            end else if (board_full) begin
               full_d  = 1'b1;
               state_d = ST_GAME_OVER;
            end else if (last_mover_q == CELL_P1) begin
               state_d = mode_q ? ST_P2_WAIT : ST_CPU_THINK;
            end else begin
               state_d = ST_P1_WAIT;
            end
         end
         default: begin
            // ST_GAME_OVER: frozen until reset.
         end
      endcase

      for (int k = 0; k < NUM_CELLS; k++) begin
         if (wr_mask[k]) board_d[2*k +: 2] = wr_code;
      end
   end

   // State and data registers; reset abandons any game in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_P1_WAIT;
         board_q      <= '0;
         last_mover_q <= CELL_EMPTY;
         mode_q       <= game_mode;
         cnt_q        <= '0;
         p1_win_q     <= 1'b0;
         p2_win_q     <= 1'b0;
         full_q       <= 1'b0;
         btn_q        <= '0;
         arm_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         board_q      <= board_d;
         last_mover_q <= last_mover_d;
         mode_q       <= mode_d;
         cnt_q        <= cnt_d;
         p1_win_q     <= p1_win_d;
         p2_win_q     <= p2_win_d;
         full_q       <= full_d;
         btn_q        <= btn;
         arm_q        <= 1'b1;
      end
   end

   assign cell_led  = board_q;
   assign p1_turn   = (state_q == ST_P1_WAIT);
   assign p2_turn   = (state_q == ST_P2_WAIT) || (state_q == ST_CPU_THINK);
   assign p1_win    = p1_win_q;
   assign p2_win    = p2_win_q;
   assign grid_full = full_q;

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Directed bench for ttt_turn_ctrl: games, illegal presses, CPU timing, reset.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: n/a.
module tb_ttt_turn_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [8:0]  btn = '0;
   logic        game_mode = 1'b1;
   logic [17:0] cell_led;
   logic        p1_turn, p2_turn, p1_win, p2_win, grid_full;

   int chk_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   ttt_turn_ctrl #(.CPU_DELAY(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn       (btn),
      .game_mode (game_mode),
      .cell_led  (cell_led),
      .p1_turn   (p1_turn),
      .p2_turn   (p2_turn),
      .p1_win    (p1_win),
      .p2_win    (p2_win),
      .grid_full (grid_full)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      chk_cnt++;
      if (obs !== want) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   // One-clock pulse on cell k; returns one clock after the accepting edge.
   task automatic press(input int k);
      btn = 9'(1) << k;
      tick();
      btn = '0;
      tick();
   endtask

   task automatic do_reset(input logic mode);
      @(negedge clk);
      btn       = '0;
      game_mode = mode;
      reset     = 1'b1;
      tick(2);
      reset     = 1'b0;
      tick(2);
   endtask

   int seq_draw[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
   int seq_wfull[9] = '{1, 0, 3, 2, 6, 4, 7, 5, 8};

   initial begin
      // Asynchronous reset, seen before any clock edge.
      #2 reset = 1'b1;
      #1;
      chk("rst_cell_led", 32'(cell_led), 0);
      chk("rst_p1_turn", 32'(p1_turn), 1);
      chk("rst_p2_turn", 32'(p2_turn), 0);
      chk("rst_flags", {29'd0, p1_win, p2_win, grid_full}, 0);
      tick(2);
      reset = 1'b0;
      tick(2);

      // P1 wins on the top row; latency of the win flag; game over freeze.
      press(0);
      chk("w_after_a_p2_turn", 32'(p2_turn), 1);
      press(3);
      press(1);
      press(4);
      btn = 9'(1) << 2;
      tick();
      chk("w_c_board_same_edge", 32'(cell_led), 661);
      chk("w_c_p1_win_not_yet", 32'(p1_win), 0);
      chk("w_c_in_eval_p1_turn", 32'(p1_turn), 0);
      btn = '0;
      tick();
      chk("w_p1_win", 32'(p1_win), 1);
      chk("w_p2_win", 32'(p2_win), 0);
      chk("w_over_turns", {30'd0, p1_turn, p2_turn}, 0);
      press(6);
      chk("w_over_board_frozen", 32'(cell_led), 661);
      chk("w_over_p1_win_sticky", 32'(p1_win), 1);

      // P2 tries to take an occupied cell.
      do_reset(1'b1);
      press(0);
      press(0);
      chk("occ_board", 32'(cell_led), 1);
      chk("occ_p2_turn", 32'(p2_turn), 1);

      // Two buttons on one clock, then a held button does not repeat.
      do_reset(1'b1);
      btn = 9'b000000011;
      tick();
      btn = '0;
      tick();
      chk("multi_board", 32'(cell_led), 0);
      chk("multi_p1_turn", 32'(p1_turn), 1);
      btn = 9'(1) << 2;
      tick(4);
      chk("held_board", 32'(cell_led), 16);
      chk("held_p2_turn", 32'(p2_turn), 1);
      btn = '0;
      tick();

      // Full-board draw.
      do_reset(1'b1);
      foreach (seq_draw[i]) press(seq_draw[i]);
      chk("draw_board", 32'(cell_led), 92761);
      chk("draw_full", 32'(grid_full), 1);
      chk("draw_wins", {30'd0, p1_win, p2_win}, 0);

      // Winning ninth move also fills the board.
      do_reset(1'b1);
      foreach (seq_wfull[i]) press(seq_wfull[i]);
      chk("wfull_board", 32'(cell_led), 88678);
      chk("wfull_p1_win", 32'(p1_win), 1);
      chk("wfull_full", 32'(grid_full), 1);
      chk("wfull_p2_win", 32'(p2_win), 0);

      // CPU opponent: mark lands exactly four clocks after entering CPU_THINK.
      do_reset(1'b0);
      press(4);
      chk("cpu_enter_p2_turn", 32'(p2_turn), 1);
      chk("cpu_enter_board", 32'(cell_led), 256);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("cpu_wait_%0d", i), 32'(cell_led), 256);
      end
      tick();
      chk("cpu_move_board", 32'(cell_led), 258);
      tick();
      chk("cpu_back_p1_turn", 32'(p1_turn), 1);

      // Mode switch mid-game is ignored: the CPU still answers.
      game_mode = 1'b1;
      press(1);
      tick(4);
      chk("cpu_mode_locked", 32'(cell_led), 294);

      // Reset during CPU_THINK with a held button.
      do_reset(1'b0);
      press(4);
      btn = 9'b000000001;
      tick();
      chk("rcpu_pre_p2_turn", 32'(p2_turn), 1);
      #2 reset = 1'b1;
      #1;
      chk("rcpu_async_board", 32'(cell_led), 0);
      chk("rcpu_async_turns", {30'd0, p1_turn, p2_turn}, 2);
      tick(2);
      reset = 1'b0;
      tick(3);
      chk("rcpu_held_no_press", 32'(cell_led), 0);
      chk("rcpu_held_p1_turn", 32'(p1_turn), 1);
      btn = '0;
      tick();
      btn = 9'b000000001;
      tick();
      chk("rcpu_repress", 32'(cell_led), 1);
      btn = '0;
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
